// File: rtl/cv32e40x_regarb_pkg.sv
// Shared types and helpers for the register arbiter.
//  - regarb_state_e : arbiter FSM states
//  - timer_width()  : width of the lock idle timer for a given timeout
package cv32e40x_regarb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } regarb_state_e;

  // The timer counts 0 .. lock_timeout-1, so clog2 bits are enough.
  // A one-bit floor keeps the vector legal when the timeout is 1 or 2.
  function automatic int timer_width(input int lock_timeout);
    return (lock_timeout <= 2) ? 1 : $clog2(lock_timeout);
  endfunction

endpackage

// File: rtl/cv32e40x_register.sv
// Enable-gated word register with asynchronous active-low reset.
//  clk           in   1           clock
//  rst_n         in   1           async active-low reset
//  clock_enable  in   1           load data_in at the next posedge
//  data_in       in   WORD_WIDTH  value to load
//  data_out      out  WORD_WIDTH  stored value
module cv32e40x_register #(
  parameter int                    WORD_WIDTH  = 32,
  parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clock_enable,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] data_out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= RESET_VALUE;
    end else if (clock_enable) begin
      data_out <= data_in;
    end
  end

endmodule

// File: rtl/cv32e40x_rr_arbiter.sv
// One-hot round-robin grant.
// Scans req starting at rr_ptr, wrapping modulo NUM_REQ, and grants the
// first set bit.
//  req         in   NUM_REQ          request vector
//  rr_ptr      in   $clog2(NUM_REQ)  highest-priority index
//  grant       out  NUM_REQ          one-hot grant, zero when no request
//  grant_idx   out  $clog2(NUM_REQ)  index of the granted bit
//  grant_valid out  1                any request granted
module cv32e40x_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_valid
);

  localparam int IW = $clog2(NUM_REQ);

  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(rr_ptr) + off;
      // Explicit wrap so a non-power-of-2 NUM_REQ goes NUM_REQ-1 -> 0.
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_valid && req[idx]) begin
        grant[idx]  = 1'b1;
        grant_idx   = IW'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cv32e40x_register_arbiter.sv
// Shares one enable-gated word register between NUM_REQ requesters.
// Round-robin arbitration in IDLE; a requester that writes with lock set
// keeps exclusive ownership (LOCKED) until it writes with lock clear or
// stays idle for LOCK_TIMEOUT cycles, in which case the lock is dropped
// and lock_abort_o pulses.
//
// state  | meaning
// IDLE   | round-robin grant among valid requesters
// LOCKED | only owner_o is granted; idle timer runs while owner not valid
//
//  clk           in   1                   clock
//  rst_n         in   1                   async active-low reset
//  req_valid_i   in   NUM_REQ             per-requester write request
//  req_lock_i    in   NUM_REQ             keep ownership after this write
//  req_data_i    in   NUM_REQ*WORD_WIDTH  write data, requester i at [i*W +: W]
//  req_ready_o   out  NUM_REQ             grant, at most one bit set
//  data_o        out  WORD_WIDTH          current register value
//  owner_o       out  $clog2(NUM_REQ)     index of the last accepted writer
//  update_o      out  1                   data_o shows newly written data
//  lock_abort_o  out  1                   one-cycle pulse on timeout release
module cv32e40x_register_arbiter
  import cv32e40x_regarb_pkg::*;
#(
  parameter int                    NUM_REQ      = 4,
  parameter int                    WORD_WIDTH   = 32,
  parameter logic [WORD_WIDTH-1:0] RESET_VALUE  = '0,
  parameter int                    LOCK_TIMEOUT = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_lock_i,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [WORD_WIDTH-1:0]         data_o,
  output logic [$clog2(NUM_REQ)-1:0]    owner_o,
  output logic                          update_o,
  output logic                          lock_abort_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = timer_width(LOCK_TIMEOUT);

  regarb_state_e   state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic            abort_d;
  logic            update_q;
  logic            abort_q;

  logic [NUM_REQ-1:0]    arb_grant;
  logic [IW-1:0]         arb_idx;
  logic                  arb_valid;
  logic [NUM_REQ-1:0]    ready;
  logic [NUM_REQ-1:0]    owner_onehot;
  logic [IW-1:0]         accept_idx;
  logic                  accept_any;
  logic [WORD_WIDTH-1:0] write_data;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) return '0;
    return idx + 1'b1;
  endfunction

  cv32e40x_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req         (req_valid_i),
    .rr_ptr      (rr_ptr_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    abort_d      = 1'b0;
    ready        = '0;
    accept_idx   = owner_q;
    accept_any   = 1'b0;
    owner_onehot = '0;
    owner_onehot[owner_q] = 1'b1;

    case (state_q)
      IDLE: begin
        // The arbiter only grants valid requesters, so grant implies accept.
        ready      = arb_grant;
        accept_idx = arb_idx;
        if (arb_valid) begin
          accept_any = 1'b1;
          owner_d    = arb_idx;
          rr_ptr_d   = next_idx(arb_idx);
          if (req_lock_i[arb_idx]) begin
            state_d = LOCKED;
            timer_d = '0;
          end
        end
      end
      LOCKED: begin
        // owner_q is the lock holder: it was the accepted writer that locked.
        ready = owner_onehot;
        if (req_valid_i[owner_q]) begin
          accept_any = 1'b1;
          timer_d    = '0;
          if (!req_lock_i[owner_q]) begin
            state_d  = IDLE;
            rr_ptr_d = next_idx(owner_q);
          end
        end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
          state_d  = IDLE;
          abort_d  = 1'b1;
          timer_d  = '0;
          rr_ptr_d = next_idx(owner_q);
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      update_q <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      update_q <= accept_any;
      abort_q  <= abort_d;
    end
  end

  assign write_data = req_data_i[int'(accept_idx)*WORD_WIDTH +: WORD_WIDTH];

  cv32e40x_register #(
    .WORD_WIDTH  (WORD_WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_register (
    .clk          (clk),
    .rst_n        (rst_n),
    .clock_enable (accept_any),
    .data_in      (write_data),
    .data_out     (data_o)
  );

  // Grants are suppressed during reset even though the FSM sits in IDLE.
  assign req_ready_o  = rst_n ? ready : '0;
  assign owner_o      = owner_q;
  assign update_o     = update_q;
  assign lock_abort_o = abort_q;

endmodule

// File: tb/tb_cv32e40x_register_arbiter.sv
module tb_cv32e40x_register_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int LT = 8;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_lock;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   data;
  logic [1:0]     owner;
  logic           update;
  logic           lock_abort;

  int checks   = 0;
  int failures = 0;

  cv32e40x_register_arbiter #(
    .NUM_REQ      (N),
    .WORD_WIDTH   (W),
    .RESET_VALUE  ('0),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_lock_i   (req_lock),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .data_o       (data),
    .owner_o      (owner),
    .update_o     (update),
    .lock_abort_o (lock_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [W-1:0] v);
    req_data[i*W +: W] = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_lock = '0; req_data = '0;
    tick();
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=00000000", data); end
    checks++; if (update !== 1'b0) begin failures++; $display("FAIL reset_update got=%b exp=0", update); end
    checks++; if (lock_abort !== 1'b0) begin failures++; $display("FAIL reset_abort got=%b exp=0", lock_abort); end
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL reset_owner got=%0d exp=0", owner); end
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL idle_noreq_ready got=%b exp=0000", req_ready); end
    checks++; if (data !== 32'h0 || update !== 1'b0) begin failures++; $display("FAIL idle_noreq_data got=%h/%b exp=00000000/0", data, update); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_ready;
    for (int i = 0; i < N; i++) set_data(i, 32'hA0 + i);
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      #1;
      exp_ready = '0;
      exp_ready[i] = 1'b1;
      checks++; if (req_ready !== exp_ready) begin failures++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, req_ready, exp_ready); end
      tick();
      checks++; if (data !== 32'hA0 + i) begin failures++; $display("FAIL rr_data[%0d] got=%h exp=%h", i, data, 32'hA0 + i); end
      checks++; if (owner !== 2'(i) || update !== 1'b1) begin failures++; $display("FAIL rr_owner_upd[%0d] got=%0d/%b exp=%0d/1", i, owner, update, i); end
    end
    req_valid = '0;
    tick();
    checks++; if (update !== 1'b0 || data !== 32'hA3) begin failures++; $display("FAIL rr_hold got=%h/%b exp=000000a3/0", data, update); end
  endtask

  task automatic test_lock_burst();
    // rr_ptr is 0 here; req1 takes the lock alone, then req0 joins.
    set_data(0, 32'hB0);
    set_data(1, 32'h11);
    req_valid = 4'b0010; req_lock = 4'b0010;
    tick();
    checks++; if (data !== 32'h11) begin failures++; $display("FAIL lock_w1 got=%h exp=00000011", data); end
    req_valid = 4'b0011; set_data(1, 32'h22);
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL lock_ready1 got=%b exp=0010", req_ready); end
    tick();
    checks++; if (data !== 32'h22 || owner !== 2'd1) begin failures++; $display("FAIL lock_w2 got=%h/%0d exp=00000022/1", data, owner); end
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL lock_ready_idle_owner got=%b exp=0010", req_ready); end
    tick();
    checks++; if (update !== 1'b0 || data !== 32'h22) begin failures++; $display("FAIL lock_hold got=%h/%b exp=00000022/0", data, update); end
    req_valid = 4'b0011; req_lock = 4'b0000; set_data(1, 32'h33);
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL lock_ready2 got=%b exp=0010", req_ready); end
    tick();
    checks++; if (data !== 32'h33) begin failures++; $display("FAIL lock_w3 got=%h exp=00000033", data); end
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL lock_release_grant got=%b exp=0001", req_ready); end
    tick();
    checks++; if (data !== 32'hB0 || owner !== 2'd0) begin failures++; $display("FAIL lock_req0_write got=%h/%0d exp=000000b0/0", data, owner); end
    req_valid = '0;
  endtask

  task automatic test_lock_timeout();
    // rr_ptr is 1 here.
    set_data(2, 32'hC2);
    req_valid = 4'b0100; req_lock = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL to_grant got=%b exp=0100", req_ready); end
    tick();
    req_valid = '0; req_lock = '0;
    for (int c = 0; c < LT; c++) begin
      #1;
      checks++; if (lock_abort !== 1'b0 || req_ready !== 4'b0100) begin failures++; $display("FAIL to_wait[%0d] got=%b/%b exp=0/0100", c, lock_abort, req_ready); end
      tick();
    end
    checks++; if (lock_abort !== 1'b1) begin failures++; $display("FAIL to_abort got=%b exp=1", lock_abort); end
    checks++; if (data !== 32'hC2 || update !== 1'b0) begin failures++; $display("FAIL to_data got=%h/%b exp=000000c2/0", data, update); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL to_idle_ready got=%b exp=0000", req_ready); end
    tick();
    checks++; if (lock_abort !== 1'b0) begin failures++; $display("FAIL to_abort_pulse got=%b exp=0", lock_abort); end
    // rr_ptr now 3: requester 0 alone must be granted in IDLE.
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL to_idle_grant got=%b exp=0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_lock();
    set_data(3, 32'h55);
    req_valid = 4'b1000; req_lock = 4'b1000;
    tick();
    req_valid = '0; req_lock = '0;
    tick();
    checks++; if (data !== 32'h55) begin failures++; $display("FAIL rml_pre got=%h exp=00000055", data); end
    rst_n = 1'b0;
    #1;
    checks++; if (data !== 32'h0 || req_ready !== 4'b0000) begin failures++; $display("FAIL rml_async got=%h/%b exp=00000000/0000", data, req_ready); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (lock_abort !== 1'b0) begin failures++; $display("FAIL rml_abort[%0d] got=%b exp=0", c, lock_abort); end
    end
    rst_n = 1'b1;
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL rml_idle got=%b exp=0010", req_ready); end
    req_valid = '0;
    tick();
    checks++; if (lock_abort !== 1'b0 || update !== 1'b0) begin failures++; $display("FAIL rml_post got=%b/%b exp=0/0", lock_abort, update); end
  endtask

  task automatic test_timeout_race();
    // rr_ptr is 0 after reset.
    set_data(0, 32'h60);
    req_valid = 4'b0001; req_lock = 4'b0001;
    tick();
    req_valid = '0; req_lock = '0;
    for (int c = 0; c < LT - 1; c++) tick();
    req_valid = 4'b0001; set_data(0, 32'h61);
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL race_ready got=%b exp=0001", req_ready); end
    tick();
    checks++; if (data !== 32'h61 || update !== 1'b1) begin failures++; $display("FAIL race_write got=%h/%b exp=00000061/1", data, update); end
    checks++; if (lock_abort !== 1'b0) begin failures++; $display("FAIL race_abort got=%b exp=0", lock_abort); end
    req_valid = '0;
    tick();
    checks++; if (lock_abort !== 1'b0) begin failures++; $display("FAIL race_abort_late got=%b exp=0", lock_abort); end
  endtask

  task automatic test_lock_without_valid();
    // rr_ptr is 1; lock bits without valid must not create a lock.
    req_lock = 4'b1111; req_valid = '0;
    tick();
    req_lock = '0;
    set_data(1, 32'h71);
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0100; set_data(2, 32'h72);
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL nolock_grant got=%b exp=0100", req_ready); end
    tick();
    checks++; if (data !== 32'h72 || owner !== 2'd2) begin failures++; $display("FAIL nolock_write got=%h/%0d exp=00000072/2", data, owner); end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock_burst();
    test_lock_timeout();
    test_reset_mid_lock();
    test_timeout_race();
    test_lock_without_valid();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
